// File: rtl/cam_pixel_packer.sv
// rtl/cam_pixel_packer.sv - frames 8-bit camera pixels and packs 16 per 128-bit DataFIFO word
module cam_pixel_packer #(
  parameter int FRAME_PIXELS = 784
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   pix_data,
  input  logic         pix_valid,
  input  logic         frame_start,
  input  logic         fifo_full,
  input  logic         clr_status,
  output logic [127:0] CamDataIn,
  output logic         CamWr_en,
  output logic         frame_done,
  output logic [15:0]  frame_count,
  output logic         overflow,
  output logic         frame_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  localparam logic [15:0] LAST_PIX = 16'(FRAME_PIXELS);

  logic [1:0]   state, state_n;
  logic [15:0]  pix_cnt, pix_cnt_n;
  logic [127:0] acc, acc_n;
  logic [127:0] lane_word;
  logic [127:0] push_data;
  logic         push;
  logic         restart;
  logic         frame_end;
  logic         pend_valid;
  logic [127:0] pend_data;

  assign CamDataIn = pend_data;
  assign CamWr_en  = pend_valid & ~fifo_full;

  always_comb begin
    state_n   = state;
    pix_cnt_n = pix_cnt;
    acc_n     = acc;
    push      = 1'b0;
    push_data = acc;
    restart   = 1'b0;
    frame_end = 1'b0;
    lane_word = acc;
    lane_word[{pix_cnt[3:0], 3'b000} +: 8] = pix_data;

    case (state)
      S_IDLE: begin
        if (pix_valid && frame_start) begin
          acc_n     = {120'b0, pix_data};
          pix_cnt_n = 16'd1;
          state_n   = (LAST_PIX == 16'd1) ? S_FLUSH : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (pix_valid) begin
          if (frame_start) begin
            // Partial word is dropped; whatever sits in the pending register survives.
            restart   = 1'b1;
            acc_n     = {120'b0, pix_data};
            pix_cnt_n = 16'd1;
          end else begin
            pix_cnt_n = pix_cnt + 16'd1;
            if (pix_cnt[3:0] == 4'hF) begin
              push      = 1'b1;
              push_data = lane_word;
              acc_n     = '0;
            end else begin
              acc_n = lane_word;
            end
            if (pix_cnt_n == LAST_PIX) begin
              state_n = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        frame_end = 1'b1;
        push      = (pix_cnt[3:0] != 4'h0);
        push_data = acc;
        acc_n     = '0;
        pix_cnt_n = '0;
        state_n   = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pix_cnt     <= '0;
      acc         <= '0;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_cnt_n;
      acc        <= acc_n;
      frame_done <= frame_end;
      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
      end

      // A word draining this edge frees the slot for a simultaneous push.
      if (push) begin
        if (!pend_valid || CamWr_en) begin
          pend_valid <= 1'b1;
          pend_data  <= push_data;
        end
      end else if (CamWr_en) begin
        pend_valid <= 1'b0;
      end

      if (push && pend_valid && !CamWr_en) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end

      if (restart) begin
        frame_err <= 1'b1;
      end else if (clr_status) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// tb/tb_cam_pixel_packer.sv - directed bench for cam_pixel_packer (784- and 20-pixel frames)
module tb_cam_pixel_packer;

  logic         clk;
  logic         rst;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         frame_start;
  logic         fifo_full;
  logic         clr_status;

  logic [127:0] a_data, b_data;
  logic         a_wr, b_wr, a_done, b_done, a_ovf, b_ovf, a_err, b_err;
  logic [15:0]  a_cnt, b_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [127:0] wq[$];
  int done_a = 0;

  cam_pixel_packer #(.FRAME_PIXELS(784)) dut_a (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .fifo_full(fifo_full), .clr_status(clr_status),
    .CamDataIn(a_data), .CamWr_en(a_wr), .frame_done(a_done),
    .frame_count(a_cnt), .overflow(a_ovf), .frame_err(a_err)
  );

  cam_pixel_packer #(.FRAME_PIXELS(20)) dut_b (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .fifo_full(fifo_full), .clr_status(clr_status),
    .CamDataIn(b_data), .CamWr_en(b_wr), .frame_done(b_done),
    .frame_count(b_cnt), .overflow(b_ovf), .frame_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_wr) wq.push_back(a_data);
    if (a_done) done_a++;
  end

  typedef struct {
    logic         valid;
    logic         fs;
    logic [7:0]   data;
    logic         full;
    logic         clr;
    logic         exp_wr;
    logic [127:0] exp_data;
    logic         exp_done;
    logic [15:0]  exp_cnt;
    logic         exp_ovf;
  } vec_t;

  vec_t vec[49];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_word(input logic [7:0] first, input int lanes);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < lanes; j++) w[8*j +: 8] = first + 8'(j);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic fs, input logic full);
    pix_valid   = 1'b1;
    pix_data    = d;
    frame_start = fs;
    fifo_full   = full;
    tick();
  endtask

  task automatic idle(input int n);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    fifo_full   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    idle(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int b, b2, d;

    // 20-pixel padded frame, then a back-pressured frame whose padded word is dropped
    for (int i = 0; i < 49; i++) begin
      vec[i].valid = 1'b0; vec[i].fs = 1'b0; vec[i].data = 8'h00;
      vec[i].full = 1'b0; vec[i].clr = 1'b0; vec[i].exp_wr = 1'b0;
      vec[i].exp_data = '0; vec[i].exp_done = 1'b0;
      vec[i].exp_cnt = (i >= 45) ? 16'd2 : (i >= 21) ? 16'd1 : 16'd0;
      vec[i].exp_ovf = (i == 45 || i == 46);
    end
    for (int k = 0; k < 20; k++) begin
      vec[k].valid = 1'b1; vec[k].fs = (k == 0); vec[k].data = 8'hA0 + 8'(k);
      vec[24+k].valid = 1'b1; vec[24+k].fs = (k == 0); vec[24+k].data = 8'h10 + 8'(k);
    end
    for (int i = 24; i <= 46; i++) vec[i].full = 1'b1;
    vec[16].exp_wr = 1'b1; vec[16].exp_data = mk_word(8'hA0, 16);
    vec[21].exp_wr = 1'b1; vec[21].exp_data = {96'h0, 32'hB3B2B1B0}; vec[21].exp_done = 1'b1;
    vec[44].clr = 1'b1;
    vec[45].exp_done = 1'b1;
    vec[46].clr = 1'b1;
    vec[47].exp_wr = 1'b1; vec[47].exp_data = mk_word(8'h10, 16);

    pix_data = 8'h00; pix_valid = 1'b0; frame_start = 1'b0;
    fifo_full = 1'b0; clr_status = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    @(negedge clk);
    check("reset_wr", 128'(a_wr), 128'd0);
    check("reset_data", a_data, 128'd0);
    check("reset_done", 128'(a_done), 128'd0);
    check("reset_cnt", 128'(a_cnt), 128'd0);
    check("reset_ovf", 128'(a_ovf), 128'd0);
    check("reset_err", 128'(a_err), 128'd0);
    tick();

    for (int i = 0; i < 49; i++) begin
      pix_valid = vec[i].valid; frame_start = vec[i].fs; pix_data = vec[i].data;
      fifo_full = vec[i].full; clr_status = vec[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d_wr", i), 128'(b_wr), 128'(vec[i].exp_wr));
      if (vec[i].exp_wr) check($sformatf("vec%0d_data", i), b_data, vec[i].exp_data);
      check($sformatf("vec%0d_done", i), 128'(b_done), 128'(vec[i].exp_done));
      check($sformatf("vec%0d_cnt", i), 128'(b_cnt), 128'(vec[i].exp_cnt));
      check($sformatf("vec%0d_ovf", i), 128'(b_ovf), 128'(vec[i].exp_ovf));
      tick();
    end
    clr_status = 1'b0;

    // Clean 784-pixel frame
    do_reset();
    b = wq.size(); d = done_a;
    for (int k = 0; k < 784; k++) send_pix(8'(k), k == 0, 1'b0);
    idle(3);
    check("clean_writes", 128'(wq.size() - b), 128'd49);
    check("clean_word0", wq[b], 128'h0F0E0D0C0B0A09080706050403020100);
    for (int w = 0; w < 49; w++) check($sformatf("clean_w%0d", w), wq[b+w], mk_word(8'(16*w), 16));
    check("clean_done", 128'(done_a - d), 128'd1);
    check("clean_cnt", 128'(a_cnt), 128'd1);
    check("clean_ovf", 128'(a_ovf), 128'd0);
    check("clean_err", 128'(a_err), 128'd0);

    // Back-pressure for 10 cycles from the moment word 0 is pending
    do_reset();
    b = wq.size();
    for (int k = 0; k < 784; k++) begin
      pix_valid = 1'b1; pix_data = 8'(k); frame_start = (k == 0);
      fifo_full = (k >= 16 && k < 26);
      if (k == 25) begin
        @(negedge clk);
        check("bp_hold", 128'(a_wr), 128'd0);
      end
      if (k == 26) begin
        @(negedge clk);
        check("bp_release_wr", 128'(a_wr), 128'd1);
        check("bp_release_data", a_data, mk_word(8'h00, 16));
      end
      tick();
    end
    idle(3);
    check("bp_writes", 128'(wq.size() - b), 128'd49);
    for (int w = 0; w < 49; w++) check($sformatf("bp_w%0d", w), wq[b+w], mk_word(8'(16*w), 16));
    check("bp_ovf", 128'(a_ovf), 128'd0);

    // Overflow: full during 40 pixels drops word 1
    do_reset();
    b = wq.size();
    for (int k = 0; k < 48; k++) send_pix(8'(k), k == 0, k < 40);
    idle(3);
    check("ovf_writes", 128'(wq.size() - b), 128'd2);
    check("ovf_first", wq[b], mk_word(8'h00, 16));
    check("ovf_second", wq[b+1], mk_word(8'h20, 16));
    check("ovf_flag", 128'(a_ovf), 128'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    check("ovf_clr", 128'(a_ovf), 128'd0);
    tick();

    // Short frame: restart at pixel 100
    do_reset();
    b = wq.size(); d = done_a;
    for (int k = 0; k < 100; k++) send_pix(8'(k), k == 0, 1'b0);
    for (int j = 0; j < 784; j++) begin
      send_pix(8'(j), j == 0, 1'b0);
      if (j == 0) begin
        check("short_err", 128'(a_err), 128'd1);
        check("short_no_done", 128'(done_a - d), 128'd0);
      end
    end
    idle(3);
    check("short_writes", 128'(wq.size() - b), 128'd55);
    for (int w = 0; w < 6; w++) check($sformatf("short_f1_w%0d", w), wq[b+w], mk_word(8'(16*w), 16));
    for (int w = 0; w < 49; w++) check($sformatf("short_f2_w%0d", w), wq[b+6+w], mk_word(8'(16*w), 16));
    check("short_done", 128'(done_a - d), 128'd1);
    check("short_cnt", 128'(a_cnt), 128'd1);

    // Reset at pixel 300 with a word held in the pending register
    for (int k = 0; k < 300; k++) send_pix(8'(k), k == 0, k >= 280);
    rst = 1'b1; pix_valid = 1'b1; pix_data = 8'(300); frame_start = 1'b0; fifo_full = 1'b0;
    tick();
    rst = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_wr", 128'(a_wr), 128'd0);
    check("rst_mid_data", a_data, 128'd0);
    check("rst_mid_done", 128'(a_done), 128'd0);
    check("rst_mid_cnt", 128'(a_cnt), 128'd0);
    check("rst_mid_ovf", 128'(a_ovf), 128'd0);
    check("rst_mid_err", 128'(a_err), 128'd0);
    tick();
    b2 = wq.size();
    for (int k = 0; k < 40; k++) send_pix(8'(k), 1'b0, 1'b0);
    idle(2);
    check("rst_no_writes", 128'(wq.size() - b2), 128'd0);
    send_pix(8'h01, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_pix(8'(k), 1'b0, 1'b0);
    send_pix(8'h09, 1'b1, 1'b0);
    idle(0);
    @(negedge clk);
    check("rst_err_set", 128'(a_err), 128'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    check("rst_err_clr", 128'(a_err), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
